string_rx: RTL and testbench

//   Byte-stream-to-string receiver: the consuming end of a character stream.

---
 rtl/string_rx.sv | 106 ++++++++++
 tb/tb_string_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/string_rx.sv
// string_rx: collects a valid/ready byte stream into a NUL-terminated string
// buffer and hands each completed string on through a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active-low
//   rx_valid   rx_data holds a byte
//   rx_ready   block accepts a byte this cycle (high in COLLECT)
//   rx_data    character byte
//   str_valid  completed string available (high in HOLD)
//   str_ready  consumer accepts the string
//   str_data   packed string, first character in the MSB byte, NUL padded
//   str_len    stored character count, 0..MAX_LEN
//   str_ovf    characters were dropped because the string exceeded MAX_LEN
module string_rx #(
    parameter int unsigned MAX_LEN = 16,
    parameter logic [7:0]  TERM    = 8'h00
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    input  logic [7:0]                     rx_data,
    output logic                           str_valid,
    input  logic                           str_ready,
    output logic [8*MAX_LEN-1:0]           str_data,
    output logic [$clog2(MAX_LEN+1)-1:0]   str_len,
    output logic                           str_ovf
);

    localparam int unsigned DATA_W = 8 * MAX_LEN;
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              rx_fire;
    logic              str_fire;
    logic              is_term;
    logic              buf_full;
    logic [DATA_W-1:0] char_slot;

    assign rx_fire   = rx_valid & rx_ready;
    assign str_fire  = str_valid & str_ready;
    assign is_term   = (rx_data == TERM);
    assign buf_full  = (str_len == LEN_W'(MAX_LEN));
    // Incoming byte moved into byte position str_len (MSB byte is position 0).
    assign char_slot = (DATA_W'(rx_data) << (DATA_W - 8)) >> {str_len, 3'b000};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (rx_fire && is_term) state_nxt = HOLD;
            HOLD:    if (str_fire)           state_nxt = COLLECT;
            default:                         state_nxt = COLLECT;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        rx_ready  = 1'b0;
        str_valid = 1'b0;
        case (state)
            COLLECT: rx_ready  = 1'b1;
            HOLD:    str_valid = 1'b1;
            default: rx_ready  = 1'b1;
        endcase
    end

    // String buffer: fill on non-terminator bytes, clear on release.
    // Unused bytes stay zero, so OR-ing the new byte into place is enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            str_data <= '0;
            str_len  <= '0;
            str_ovf  <= 1'b0;
        end else if (str_fire) begin
            str_data <= '0;
            str_len  <= '0;
            str_ovf  <= 1'b0;
        end else if (rx_fire && !is_term) begin
            if (buf_full) begin
                str_ovf <= 1'b1;
            end else begin
                str_data <= str_data | char_slot;
                str_len  <= str_len + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_string_rx.sv
// Bench for string_rx: directed scenarios plus randomized strings, checked
// every cycle against a queue-based model of the string currently held.
module tb_string_rx;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned DATA_W  = 8 * MAX_LEN;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic              clk;
    logic              rst_n;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              str_valid;
    logic              str_ready;
    logic [DATA_W-1:0] str_data;
    logic [LEN_W-1:0]  str_len;
    logic              str_ovf;

    string_rx #(.MAX_LEN(MAX_LEN), .TERM(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .str_valid (str_valid),
        .str_ready (str_ready),
        .str_data  (str_data),
        .str_len   (str_len),
        .str_ovf   (str_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  nvec  = 0;
    int  nerr  = 0;
    bit  rnd   = 1'b0;
    int  nrel  = 0;

    // Model: characters of the current string, and whether it is complete
    // and waiting for the consumer.
    logic [7:0] cur[$];
    bit         pending;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur.delete();
            pending = 1'b0;
        end else if (pending) begin
            if (str_ready) begin
                cur.delete();
                pending = 1'b0;
                nrel++;
            end
        end else if (rx_valid) begin
            if (rx_data == 8'h00) pending = 1'b1;
            else                  cur.push_back(rx_data);
        end
    end

    function automatic logic [DATA_W-1:0] exp_data();
        logic [DATA_W-1:0] d = '0;
        for (int i = 0; i < cur.size() && i < int'(MAX_LEN); i++)
            d[8*(int'(MAX_LEN)-1-i) +: 8] = cur[i];
        return d;
    endfunction

    function automatic logic [LEN_W-1:0] exp_len();
        return (cur.size() > int'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN_W'(cur.size());
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one byte and wait (bounded) for it to be accepted.
    task automatic send(input logic [7:0] b);
        bit r;
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            if (rnd) str_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            #1;
            if (r) break;
            if (++n > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_str(input string s, input bit term);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        if (term) send(8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rnd) begin
                str_ready = ($urandom_range(0, 2) != 0);
                rx_valid  = 1'b0;
                rx_data   = 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [95:0]  s_hello;
    logic [55:0]  s_finish;
    logic [127:0] s_ovf;
    logic [15:0]  s_ok;

    initial begin
        s_hello  = "Hello world!";
        s_finish = "Finish.";
        s_ovf    = "ABCDEFGHIJKLMNOP";
        s_ok     = "ok";
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        str_ready = 1'b1;

        // Every-cycle comparison of all outputs against the model.
        fork
            forever begin
                @(negedge clk);
                chk("rx_ready",  DATA_W'(rx_ready),  DATA_W'(!pending));
                chk("str_valid", DATA_W'(str_valid), DATA_W'(pending));
                chk("str_len",   DATA_W'(str_len),   DATA_W'(exp_len()));
                chk("str_ovf",   DATA_W'(str_ovf),   DATA_W'(cur.size() > int'(MAX_LEN)));
                chk("str_data",  str_data,           exp_data());
            end
        join_none

        #1;
        chk("rst_rx_ready",  DATA_W'(rx_ready),  DATA_W'(1));
        chk("rst_str_valid", DATA_W'(str_valid), DATA_W'(0));
        chk("rst_str_data",  str_data,           DATA_W'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 basic string
        send_str("Hello world!", 1'b1);
        chk("t1_valid", DATA_W'(str_valid),     DATA_W'(1));
        chk("t1_len",   DATA_W'(str_len),       DATA_W'(12));
        chk("t1_hi",    DATA_W'(str_data[127:32]), DATA_W'(s_hello));
        chk("t1_lo",    DATA_W'(str_data[31:0]),   DATA_W'(0));
        chk("t1_ovf",   DATA_W'(str_ovf),       DATA_W'(0));

        // T2 empty string
        send(8'h00);
        chk("t2_valid", DATA_W'(str_valid), DATA_W'(1));
        chk("t2_len",   DATA_W'(str_len),   DATA_W'(0));
        chk("t2_data",  str_data,           DATA_W'(0));

        // T3 sequence, T4 backpressure on the last string
        send(8'h00);
        send_str("Hello world!", 1'b1);
        send_str("Finish.", 1'b0);
        str_ready = 1'b0;
        send(8'h00);
        chk("t3_len", DATA_W'(str_len),           DATA_W'(7));
        chk("t3_hi",  DATA_W'(str_data[127:72]),  DATA_W'(s_finish));
        repeat (5) begin
            @(negedge clk);
            chk("t4_rx_ready", DATA_W'(rx_ready), DATA_W'(0));
            chk("t4_len",      DATA_W'(str_len),  DATA_W'(7));
            @(posedge clk);
            #1;
        end
        str_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_released", DATA_W'(str_valid), DATA_W'(0));

        // T5 overflow, then a following string with the flag cleared
        send_str("ABCDEFGHIJKLMNOPQRST", 1'b1);
        chk("t5_len",  DATA_W'(str_len), DATA_W'(16));
        chk("t5_data", str_data,         DATA_W'(s_ovf));
        chk("t5_ovf",  DATA_W'(str_ovf), DATA_W'(1));
        send_str("Z", 1'b1);
        chk("t5_next_ovf", DATA_W'(str_ovf), DATA_W'(0));
        chk("t5_next_len", DATA_W'(str_len), DATA_W'(1));

        // T6 asynchronous reset mid-string
        send_str("Hel", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_len",   DATA_W'(str_len),   DATA_W'(0));
        chk("t6_data",  str_data,           DATA_W'(0));
        chk("t6_ready", DATA_W'(rx_ready),  DATA_W'(1));
        chk("t6_valid", DATA_W'(str_valid), DATA_W'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_str("ok", 1'b1);
        chk("t6_ok_len",  DATA_W'(str_len),            DATA_W'(2));
        chk("t6_ok_data", DATA_W'(str_data[127:112]),  DATA_W'(s_ok));
        chk("t6_ok_rest", DATA_W'(str_data[111:0]),    DATA_W'(0));

        // Randomized strings with random gaps and consumer stalls
        rnd = 1'b1;
        for (int s = 0; s < 150; s++) begin
            int len = $urandom_range(0, 20);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(8'($urandom_range(1, 255)));
            end
            send(8'h00);
        end
        rnd = 1'b0;
        str_ready = 1'b1;
        idle(5);
        chk("all_released", DATA_W'(str_valid), DATA_W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
